// File: rtl/alu_operand_issue.sv
// ---------------------------------------------------------------------------
// alu_operand_issue
//
// Buffers operand pairs from a producer in a small FIFO and issues them to an
// ALU through a registered output stage with a valid/ready handshake.
//
// Parameters:
//   DATA_W  width of each operand
//   DEPTH   FIFO entries (power of two, 2..16)
//
// Ports:
//   Clk       clock, all state updates on the rising edge
//   Rst       asynchronous, active-high reset
//   InValid   producer presents a pair (InArgA, InArgB)
//   InArgA    producer operand A
//   InArgB    producer operand B
//   InReady   block accepts a pair this cycle (Count != DEPTH)
//   ArgA      registered operand A to the ALU
//   ArgB      registered operand B to the ALU
//   ArgValid  ArgA/ArgB hold a valid pair
//   ArgReady  ALU consumes the pair this cycle
//   Count     pairs held in the FIFO, output stage excluded
//
// Build option:
//   ALU_ISSUE_BYPASS_EN  when defined, a pair pushed while the FIFO is empty
//                        and the output stage can load goes straight into
//                        ArgA/ArgB (1-cycle latency). Otherwise every pair
//                        passes through the FIFO (2-cycle latency).
//
// Output-stage FSM:
//   state | meaning
//   IDLE  | output stage empty, ArgValid=0, ArgReady ignored
//   HOLD  | ArgA/ArgB hold a pair, ArgValid=1, held until ArgReady
// ---------------------------------------------------------------------------
module alu_operand_issue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     InValid,
  input  logic [DATA_W-1:0]        InArgA,
  input  logic [DATA_W-1:0]        InArgB,
  output logic                     InReady,
  output logic [DATA_W-1:0]        ArgA,
  output logic [DATA_W-1:0]        ArgB,
  output logic                     ArgValid,
  input  logic                     ArgReady,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;

  logic push;
  logic pop;
  logic load_ok;
  logic fifo_empty;
  logic fifo_wr;
  logic bypass;

  // InReady depends only on the registered count, so ArgReady never reaches it.
  assign InReady    = (count_q != CNT_W'(DEPTH));
  assign Count      = count_q;
  assign ArgValid   = (state == HOLD);
  assign fifo_empty = (count_q == '0);

  // Rst gates push so a pair presented during reset is never stored.
  assign push    = InValid && InReady && !Rst;
  // The output stage can take a new pair when empty, or when the ALU is
  // consuming the current one.
  assign load_ok = (state == IDLE) || ArgReady;
  assign pop     = load_ok && !fifo_empty;

`ifdef ALU_ISSUE_BYPASS_EN
  assign bypass = push && fifo_empty && load_ok;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_wr = push && !bypass;

  always_comb begin
    count_nxt = count_q;
    if (fifo_wr && !pop) begin
      count_nxt = count_q + 1'b1;
    end else if (!fifo_wr && pop) begin
      count_nxt = count_q - 1'b1;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge Clk) begin
    if (fifo_wr) begin
      mem_a[wr_ptr] <= InArgA;
      mem_b[wr_ptr] <= InArgB;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      ArgA  <= '0;
      ArgB  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            ArgA  <= mem_a[rd_ptr];
            ArgB  <= mem_b[rd_ptr];
            state <= HOLD;
          end else if (bypass) begin
            ArgA  <= InArgA;
            ArgB  <= InArgB;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (ArgReady) begin
            if (pop) begin
              ArgA <= mem_a[rd_ptr];
              ArgB <= mem_b[rd_ptr];
            end else if (bypass) begin
              ArgA <= InArgA;
              ArgB <= InArgB;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_issue.sv
module tb_alu_operand_issue;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
`ifdef ALU_ISSUE_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              Clk;
  logic              Rst;
  logic              InValid;
  logic [DATA_W-1:0] InArgA;
  logic [DATA_W-1:0] InArgB;
  logic              InReady;
  logic [DATA_W-1:0] ArgA;
  logic [DATA_W-1:0] ArgB;
  logic              ArgValid;
  logic              ArgReady;
  logic [$clog2(DEPTH):0] Count;

  int errors = 0;
  int checks = 0;

  alu_operand_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .InValid  (InValid),
    .InArgA   (InArgA),
    .InArgB   (InArgB),
    .InReady  (InReady),
    .ArgA     (ArgA),
    .ArgB     (ArgB),
    .ArgValid (ArgValid),
    .ArgReady (ArgReady),
    .Count    (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic push_one(input int a, input int b);
    InValid = 1'b1;
    InArgA  = a;
    InArgB  = b;
    step();
    InValid = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b1; InValid = 1'b1; InArgA = 32'd55; InArgB = 32'd66; ArgReady = 1'b0;
    #1;
    checks++; if (ArgValid !== 1'b0) begin errors++; $display("FAIL reset_argvalid got=%0b want=0", ArgValid); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", Count); end
    checks++; if (ArgA !== 32'd0 || ArgB !== 32'd0) begin errors++; $display("FAIL reset_args got=%0d,%0d want=0,0", ArgA, ArgB); end
    checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL reset_inready got=%0b want=1", InReady); end
    step();
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_nopush got=%0d want=0", Count); end
    InValid = 1'b0;
    Rst = 1'b0;
    step();
  endtask

  task automatic test_single(input int a, input int b, input string tag);
    ArgReady = 1'b1;
    push_one(a, b);
    for (int i = 1; i < LAT; i++) begin
      checks++; if (ArgValid !== 1'b0) begin errors++; $display("FAIL %s_early got=%0b want=0", tag, ArgValid); end
      step();
    end
    checks++; if (ArgValid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%0b want=1", tag, ArgValid); end
    checks++; if (ArgA !== a || ArgB !== b) begin errors++; $display("FAIL %s_data got=%0d,%0d want=%0d,%0d", tag, ArgA, ArgB, a, b); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL %s_count got=%0d want=0", tag, Count); end
    step();
    checks++; if (ArgValid !== 1'b0) begin errors++; $display("FAIL %s_idle got=%0b want=0", tag, ArgValid); end
  endtask

  task automatic test_backpressure;
    ArgReady = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      InValid = 1'b1; InArgA = i; InArgB = i + 1;
      checks++; if (InReady !== (i <= 5)) begin errors++; $display("FAIL bp_inready_%0d got=%0b want=%0b", i, InReady, (i <= 5)); end
      step();
    end
    InValid = 1'b0;
    checks++; if (Count !== 3'd4) begin errors++; $display("FAIL bp_count_full got=%0d want=4", Count); end
    checks++; if (InReady !== 1'b0) begin errors++; $display("FAIL bp_inready_full got=%0b want=0", InReady); end
    checks++; if (ArgValid !== 1'b1 || ArgA !== 32'd1 || ArgB !== 32'd2) begin errors++; $display("FAIL bp_hold got=%0b:%0d,%0d want=1:1,2", ArgValid, ArgA, ArgB); end
    ArgReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (ArgA !== 2 + k || ArgB !== 3 + k) begin errors++; $display("FAIL bp_drain_%0d got=%0d,%0d want=%0d,%0d", k, ArgA, ArgB, 2 + k, 3 + k); end
      checks++; if (Count !== 3 - k) begin errors++; $display("FAIL bp_drain_count_%0d got=%0d want=%0d", k, Count, 3 - k); end
      if (k == 0) begin
        checks++; if (InReady !== 1'b1) begin errors++; $display("FAIL bp_inready_after got=%0b want=1", InReady); end
      end
    end
    step();
    checks++; if (ArgValid !== 1'b0) begin errors++; $display("FAIL bp_end_idle got=%0b want=0 (refused pair leaked?)", ArgValid); end
  endtask

  task automatic test_stall;
    ArgReady = 1'b0;
    push_one(10, 20);
    push_one(11, 21);
    push_one(12, 22);
    for (int s = 0; s < 3; s++) begin
      checks++; if (ArgValid !== 1'b1 || ArgA !== 32'd10 || ArgB !== 32'd20) begin errors++; $display("FAIL stall_hold_%0d got=%0b:%0d,%0d want=1:10,20", s, ArgValid, ArgA, ArgB); end
      step();
    end
    checks++; if (ArgA !== 32'd10 || Count !== 3'd2) begin errors++; $display("FAIL stall_end got=%0d/cnt%0d want=10/cnt2", ArgA, Count); end
    ArgReady = 1'b1;
    step();
    checks++; if (ArgA !== 32'd11 || ArgB !== 32'd21) begin errors++; $display("FAIL stall_rel1 got=%0d,%0d want=11,21", ArgA, ArgB); end
    step();
    checks++; if (ArgA !== 32'd12 || ArgB !== 32'd22) begin errors++; $display("FAIL stall_rel2 got=%0d,%0d want=12,22", ArgA, ArgB); end
    step();
    checks++; if (ArgValid !== 1'b0) begin errors++; $display("FAIL stall_idle got=%0b want=0", ArgValid); end
  endtask

  task automatic test_back_to_back;
    ArgReady = 1'b0;
    push_one(100, 1100);
    push_one(101, 1101);
    push_one(102, 1102);
    checks++; if (Count !== 3'd2 || ArgA !== 32'd100) begin errors++; $display("FAIL b2b_setup got=cnt%0d/%0d want=cnt2/100", Count, ArgA); end
    ArgReady = 1'b1;
    InValid  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      InArgA = 102 + k; InArgB = 1102 + k;
      step();
      checks++; if (ArgA !== 100 + k || ArgB !== 1100 + k) begin errors++; $display("FAIL b2b_data_%0d got=%0d,%0d want=%0d,%0d", k, ArgA, ArgB, 100 + k, 1100 + k); end
      checks++; if (Count !== 3'd2) begin errors++; $display("FAIL b2b_count_%0d got=%0d want=2", k, Count); end
    end
    InValid = 1'b0;
    step();
    checks++; if (ArgA !== 32'd111) begin errors++; $display("FAIL b2b_drain1 got=%0d want=111", ArgA); end
    step();
    checks++; if (ArgA !== 32'd112) begin errors++; $display("FAIL b2b_drain2 got=%0d want=112", ArgA); end
    step();
    checks++; if (ArgValid !== 1'b0 || Count !== 3'd0) begin errors++; $display("FAIL b2b_idle got=%0b/cnt%0d want=0/cnt0", ArgValid, Count); end
  endtask

  task automatic test_reset_mid;
    ArgReady = 1'b0;
    push_one(20, 30);
    push_one(21, 31);
    push_one(22, 32);
    push_one(23, 33);
    checks++; if (Count !== 3'd3 || ArgA !== 32'd20) begin errors++; $display("FAIL mid_setup got=cnt%0d/%0d want=cnt3/20", Count, ArgA); end
    ArgReady = 1'b1;
    push_one(24, 34);
    checks++; if (Count !== 3'd3 || ArgA !== 32'd21) begin errors++; $display("FAIL mid_pushpop3 got=cnt%0d/%0d want=cnt3/21", Count, ArgA); end
    ArgReady = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    checks++; if (ArgValid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got=%0b want=0", ArgValid); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL mid_rst_count got=%0d want=0", Count); end
    checks++; if (ArgA !== 32'd0 || ArgB !== 32'd0) begin errors++; $display("FAIL mid_rst_args got=%0d,%0d want=0,0", ArgA, ArgB); end
    InValid = 1'b1; InArgA = 77; InArgB = 77;
    step();
    checks++; if (Count !== 3'd0 || InReady !== 1'b1) begin errors++; $display("FAIL mid_rst_nopush got=cnt%0d/rdy%0b want=cnt0/rdy1", Count, InReady); end
    InValid = 1'b0;
    Rst = 1'b0;
    test_single(9, 9, "post_rst");
  endtask

  task automatic test_idle_ready;
    ArgReady = 1'b1;
    InValid  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (ArgValid !== 1'b0 || Count !== 3'd0) begin errors++; $display("FAIL idle_ready_%0d got=%0b/cnt%0d want=0/cnt0", c, ArgValid, Count); end
    end
  endtask

  initial begin
    test_reset();
    test_single(5, 7, "single");
    test_backpressure();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_idle_ready();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
